// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - RV32A atomic read-modify-write sequencer with LR/SC reservation
module amo_sequencer #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [3:0]    amoop_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] rs2_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [DW-1:0] rd_data_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic [3:0]    mem_mask_o,
   input  logic          mem_gnt_i,
   input  logic          mem_rvalid_i,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          ext_wr_i,
   input  logic [AW-1:0] ext_addr_i
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_REQ  = 3'd1;
   localparam logic [2:0] RD_WAIT = 3'd2;
   localparam logic [2:0] WR_REQ  = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [3:0] OP_LR   = 4'd0;
   localparam logic [3:0] OP_SC   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_MIN  = 4'd7;
   localparam logic [3:0] OP_MAX  = 4'd8;
   localparam logic [3:0] OP_MINU = 4'd9;
   localparam logic [3:0] OP_MAXU = 4'd10;

   logic [2:0]    state;
   logic [3:0]    op;
   logic [AW-3:0] word;
   logic [DW-1:0] rs2;
   logic [DW-1:0] old;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] new_val;
   logic          resv_valid;
   logic [AW-3:0] resv_word;
   logic          snoop_hit;
   logic          sc_ok;
   logic          rd_accept;
   logic [2:0]    after_read;
   logic          req;
   logic          unused_bits;

   assign unused_bits = ^{addr_i[1:0], ext_addr_i[1:0]};

   // Snoop is folded into the SC decision so a same-cycle external write makes the SC fail.
   assign snoop_hit  = ext_wr_i && (ext_addr_i[AW-1:2] == resv_word);
   assign sc_ok      = resv_valid && !snoop_hit && (addr_i[AW-1:2] == resv_word);
   assign rd_accept  = ((state == RD_REQ) && mem_gnt_i && mem_rvalid_i) ||
                       ((state == RD_WAIT) && mem_rvalid_i);
   assign after_read = (op == OP_LR) ? DONE : WR_REQ;

   always_comb begin
      new_val = rs2;
      case (op)
         OP_ADD:  new_val = old + rs2;
         OP_XOR:  new_val = old ^ rs2;
         OP_AND:  new_val = old & rs2;
         OP_OR:   new_val = old | rs2;
         OP_MIN:  new_val = ($signed(old) <= $signed(rs2)) ? old : rs2;
         OP_MAX:  new_val = ($signed(old) >= $signed(rs2)) ? old : rs2;
         OP_MINU: new_val = (old <= rs2) ? old : rs2;
         OP_MAXU: new_val = (old >= rs2) ? old : rs2;
         default: new_val = rs2;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         op         <= '0;
         word       <= '0;
         rs2        <= '0;
         old        <= '0;
         rd_data    <= '0;
         resv_valid <= 1'b0;
         resv_word  <= '0;
      end else begin
         if (snoop_hit)
            resv_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  op   <= amoop_i;
                  word <= addr_i[AW-1:2];
                  rs2  <= rs2_i;
                  if (amoop_i == OP_SC) begin
                     resv_valid <= 1'b0;
                     if (sc_ok) begin
                        state <= WR_REQ;
                     end else begin
                        rd_data <= DW'(1);
                        state   <= DONE;
                     end
                  end else begin
                     state <= RD_REQ;
                  end
               end
            end
            RD_REQ:  if (mem_gnt_i) state <= mem_rvalid_i ? after_read : RD_WAIT;
            RD_WAIT: if (mem_rvalid_i) state <= after_read;
            WR_REQ: begin
               if (mem_gnt_i) begin
                  rd_data <= (op == OP_SC) ? '0 : old;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
         // Placed after the snoop clear so an LR completing in a snoop cycle keeps its reservation.
         if (rd_accept) begin
            old <= mem_rdata_i;
            if (op == OP_LR) begin
               rd_data    <= mem_rdata_i;
               resv_valid <= 1'b1;
               resv_word  <= word;
            end
         end
      end
   end

   assign req         = (state == RD_REQ) || (state == WR_REQ);
   assign busy_o      = start_i | ((state != IDLE) && (state != DONE));
   assign done_o      = (state == DONE);
   assign rd_data_o   = rd_data;
   assign mem_req_o   = req;
   assign mem_we_o    = (state == WR_REQ);
   assign mem_addr_o  = req ? {word, 2'b00} : '0;
   assign mem_wdata_o = (state == WR_REQ) ? new_val : '0;
   assign mem_mask_o  = req ? 4'hF : 4'h0;

endmodule
